timer_apb_arbiter: RTL
======================

// Module: timer_apb_arbiter
// PURPOSE
//  APB master that shares the 8-bit timer's APB slave port between NREQ
//    on-chip requesters. Example requesters: CPU bridge, DMA, test sequencer.
//  Round-robin arbitration runs among pending register commands. Each winning
//    command runs as one APB transfer (SETUP then ACCESS). Read data and error
//    status return to the winner only.
//  Sits between the requesters and the timer's psel/penable/pwrite/paddr/
//    pwdata/prdata/pready/pslverr port.
// PARAMETERS
//  NREQ     2   number of requesters (>=2)
//  TIMEOUT  16  max ACCESS cycles waiting for pready before abort (>=2)
// PORTS
//  pclk        in   1       APB clock; sole clock
//  presetn     in   1       async active-low reset
//  req_valid   in   NREQ    command pending; hold with fields stable until req_ready
//  req_write   in   NREQ    1=write, 0=read
//  req_addr    in   NREQ*8  register address; slice i belongs to requester i
//  req_wdata   in   NREQ*8  write data; slice i belongs to requester i
//  req_ready   out  NREQ    one-hot accept strobe, 1 cycle
//  rsp_valid   out  NREQ    one-hot completion strobe, 1 cycle
//  rsp_rdata   out  8       read data; valid with rsp_valid; 0 for writes and aborts
//  rsp_err     out  1       pslverr or timeout; valid with rsp_valid
//  psel        out  1       APB select
//  penable     out  1       APB enable
//  pwrite      out  1       APB direction
//  paddr       out  8       APB address
//  pwdata      out  8       APB write data
//  prdata      in   8       APB read data
//  pready      in   1       APB ready
//  pslverr     in   1       APB slave error
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. RR pointer last=NREQ-1, so req0 wins first.
//  IDLE
//    - If any req_valid is set, grant g = first set bit scanning last+1, last+2, ... (mod NREQ).
//    - req_ready[g]=1 combinationally this cycle.
//    - Latch write/addr/wdata of g; set last=g; go to SETUP.
//  SETUP: psel=1, penable=0; paddr/pwrite/pwdata = latched values; clear
//    timeout counter; go to ACCESS.
//  ACCESS: psel=1, penable=1; address, data and direction held stable.
//    - pready=1: complete. Capture prdata for reads (0 for writes), capture
//      pslverr. Go to IDLE.
//    - pready=0: counter++. On the TIMEOUT-th ACCESS cycle with pready still 0,
//      abort with rsp_err=1, rsp_rdata=0. Go to IDLE.
//  Response: rsp_valid[g], rsp_rdata and rsp_err are registered. They assert for
//    exactly the first IDLE cycle after ACCESS, then rsp_valid clears.
//    rsp_rdata and rsp_err hold until the next completion.
//  Throughput: min 3 cycles per transfer (IDLE, SETUP, ACCESS).
//    - A new grant may occur in the same IDLE cycle that a response is issued.
//    - psel drops for that IDLE cycle; no back-to-back ACCESS.
//  req_valid changes after grant do not affect an in-flight transfer.
//    Non-granted requesters wait; no starvation (each waits <= NREQ-1 grants).
//  Simultaneous requests: lowest index after last wins.
//    Example: req0 and req1 held continuously alternate 0,1,0,1.
//  Reset asserted mid-transfer
//    - psel/penable drop immediately; in-flight command is lost.
//    - No rsp_valid is issued for it; RR pointer returns to NREQ-1.
//  pslverr is sampled only when penable=1 and pready=1; ignored otherwise.
//  Illegal parameter values are not checked.
// TESTING
//  1 req0 write 0x01<=0x55 -> req_ready[0] pulse; SETUP with psel=1, penable=0,
//    paddr=0x01, pwdata=0x55, pwrite=1; ACCESS with pready=1 -> rsp_valid[0]=1,
//    rsp_err=0, rsp_rdata=0x00.
//  2 req1 read 0x02, slave prdata=0xA5 with pready low 3 cycles -> ACCESS held
//    4 cycles, paddr stable -> rsp_valid[1]=1, rsp_rdata=0xA5.
//  3 req0 and req1 both valid from reset, held for 4 transfers -> grant order
//    0,1,0,1; each rsp_valid goes only to its own requester.
//  4 pready held 0 -> after 16 ACCESS cycles psel=0, rsp_valid pulse with
//    rsp_err=1, rsp_rdata=0x00; next request proceeds normally.
//  5 pready=1 with pslverr=1 on a write -> rsp_err=1, bus released next cycle.
//  6 presetn low during ACCESS -> psel and penable 0 asynchronously; no rsp_valid
//    after release; with both requests pending, first grant is req0.

Source files
------------

// File: rtl/timer_apb_arbiter_if.sv
// Requester command/response bundle plus the APB master port of the arbiter.
// The master modport is the arbiter side; slave is the surrounding environment.
interface timer_apb_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*8-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [7:0]        paddr;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/timer_apb_arbiter.sv
// Round-robin APB master sharing the timer register port among NREQ requesters.
// One SETUP+ACCESS transfer per grant; responses return only to the winner.
module timer_apb_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input logic                 pclk,
    input logic                 presetn,
    timer_apb_arbiter_if.master bus
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LW-1:0] LAST_IDX = LW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   owner;
    logic [TW-1:0]   cnt;

    logic            sel;
    logic            enable;
    logic            dir;
    logic [7:0]      addr;
    logic [7:0]      wdata;
    logic [NREQ-1:0] rsp_hit;
    logic [7:0]      rdata;
    logic            err;

    logic            gnt_any;
    logic [LW-1:0]   gnt_idx;
    logic [LW-1:0]   scan;

    // Scan last+1, last+2, ... with wrap; first pending requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = (last == LAST_IDX) ? '0 : last + 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && bus.req_valid[scan]) begin
                gnt_any = 1'b1;
                gnt_idx = scan;
            end
            scan = (scan == LAST_IDX) ? '0 : scan + 1'b1;
        end
    end

    assign bus.req_ready = (presetn && state == IDLE && gnt_any)
                         ? (NREQ'(1) << gnt_idx) : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            last    <= LAST_IDX;
            owner   <= '0;
            cnt     <= '0;
            sel     <= 1'b0;
            enable  <= 1'b0;
            dir     <= 1'b0;
            addr    <= 8'h00;
            wdata   <= 8'h00;
            rsp_hit <= '0;
            rdata   <= 8'h00;
            err     <= 1'b0;
        end else begin
            rsp_hit <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner <= gnt_idx;
                        last  <= gnt_idx;
                        dir   <= bus.req_write[gnt_idx];
                        addr  <= bus.req_addr[{gnt_idx, 3'b000} +: 8];
                        wdata <= bus.req_wdata[{gnt_idx, 3'b000} +: 8];
                        sel   <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    enable <= 1'b1;
                    cnt    <= '0;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        sel     <= 1'b0;
                        enable  <= 1'b0;
                        rsp_hit <= NREQ'(1) << owner;
                        rdata   <= dir ? 8'h00 : bus.prdata;
                        err     <= bus.pslverr;
                        state   <= IDLE;
                    end else if (cnt == TW'(TIMEOUT - 1)) begin
                        // Slave never answered: abort with an error response.
                        sel     <= 1'b0;
                        enable  <= 1'b0;
                        rsp_hit <= NREQ'(1) << owner;
                        rdata   <= 8'h00;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    sel    <= 1'b0;
                    enable <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.psel      = sel;
    assign bus.penable   = enable;
    assign bus.pwrite    = dir;
    assign bus.paddr     = addr;
    assign bus.pwdata    = wdata;
    assign bus.rsp_valid = rsp_hit;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
endmodule
